// File: rtl/lm70_spi_responder.sv
// LM70-compatible SPI responder: serialises an 11-bit temperature, MSB first,
// over CS/SCK/SIO, with CS and SCK oversampled on the system clock.
// Optional build macro: LM70_SHUTDOWN_EN adds an 8-bit command phase after
// the 16-bit frame (8'hFF = shutdown, 8'h00 = wake) and the 16'h8001 ID word.
// Ports:
//   clk, rst_n             system clock, synchronous active-low reset
//   temp_in/valid/ready    host temperature handshake (ready = ~busy)
//   cs_n, sck, sio_in      SPI pins from the master (asynchronous)
//   sio_out, sio_oe        SIO data and output enable
//   busy, frame_done       frame in progress, 16-bit frame complete pulse
module lm70_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] temp_in,
    input  logic        temp_valid,
    output logic        temp_ready,
    input  logic        cs_n,
    input  logic        sck,
    input  logic        sio_in,
    output logic        sio_out,
    output logic        sio_oe,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        TAIL,
        CMD,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   cs_prev;
    logic                   sck_prev;
    logic                   arm;
    logic                   cs_s;
    logic                   sck_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_fall;

    logic [10:0] temp_hold;
    logic [15:0] shreg, sh_nx;
    logic [4:0]  cnt, cnt_nx;
    logic        done_nx;
    logic [15:0] frame_word;

    assign cs_s  = cs_q[SYNC_STAGES-1];
    assign sck_s = sck_q[SYNC_STAGES-1];

    // After reset the CS chain holds its reset value, so a fall is only
    // honoured once a genuine synchronised CS high has been seen.
    assign cs_fall  = arm & cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_fall = sck_prev & ~sck_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_q     <= '1;
            sck_q    <= '0;
            vld_q    <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
            arm      <= 1'b0;
        end else begin
            cs_q     <= {cs_q[SYNC_STAGES-2:0], cs_n};
            sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
            vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            cs_prev  <= cs_s;
            sck_prev <= sck_s;
            arm      <= arm | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end

    assign busy       = ~cs_prev;
    assign temp_ready = ~busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            temp_hold <= 11'h000;
        end else if (temp_valid && temp_ready) begin
            temp_hold <= temp_in;
        end
    end

`ifdef LM70_SHUTDOWN_EN
    logic [SYNC_STAGES-1:0] sio_q;
    logic                   sio_s;
    logic                   sck_rise;
    logic [7:0]             cmd_reg, cmd_nx;
    logic                   shutdown, sd_nx;

    assign sio_s    = sio_q[SYNC_STAGES-1];
    assign sck_rise = ~sck_prev & sck_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sio_q    <= '0;
            cmd_reg  <= 8'h00;
            shutdown <= 1'b0;
        end else begin
            sio_q    <= {sio_q[SYNC_STAGES-2:0], sio_in};
            cmd_reg  <= cmd_nx;
            shutdown <= sd_nx;
        end
    end

    assign frame_word = shutdown ? 16'h8001 : {temp_hold, 5'b11111};
`else
    logic unused_sio;
    assign unused_sio = sio_in;
    assign frame_word = {temp_hold, 5'b11111};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= 16'h0000;
            cnt        <= 5'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= sh_nx;
            cnt        <= cnt_nx;
            frame_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = shreg;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
`ifdef LM70_SHUTDOWN_EN
        cmd_nx   = cmd_reg;
        sd_nx    = shutdown;
`endif
        // CS rise wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
            state_nx = IDLE;
            cnt_nx   = 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        sh_nx    = frame_word;
                        cnt_nx   = 5'd0;
                        state_nx = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_fall) begin
                        sh_nx  = {shreg[14:0], 1'b0};
                        cnt_nx = cnt + 5'd1;
                        if (cnt == 5'd15) begin
                            done_nx = 1'b1;
`ifdef LM70_SHUTDOWN_EN
                            cnt_nx   = 5'd0;
                            state_nx = CMD;
`else
                            state_nx = TAIL;
`endif
                        end
                    end
                end
                TAIL: begin
                    state_nx = TAIL;
                end
`ifdef LM70_SHUTDOWN_EN
                CMD: begin
                    if (sck_rise) begin
                        cmd_nx = {cmd_reg[6:0], sio_s};
                        cnt_nx = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            state_nx = HOLD;
                            if (cmd_nx == 8'hFF) begin
                                sd_nx = 1'b1;
                            end else if (cmd_nx == 8'h00) begin
                                sd_nx = 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    state_nx = HOLD;
                end
`endif
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Output enable is gated by rst_n so it drops in the reset cycle itself.
    assign sio_oe  = rst_n & ((state == SHIFT) | (state == TAIL));
    assign sio_out = (state == SHIFT) ? shreg[15] : 1'b0;

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Self-checking bench for lm70_spi_responder: bit-banged LM70 master with a
// scoreboard of expected read words and a small temp/shutdown model.
module tb_lm70_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] temp_in = 11'h000;
    logic        temp_valid = 1'b0;
    logic        temp_ready;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic        sio_in = 1'b0;
    logic        sio_out;
    logic        sio_oe;
    logic        busy;
    logic        frame_done;

    int n_chk = 0;
    int n_pass = 0;
    int done_cyc = 0;

    logic [10:0] m_hold = 11'h000;
    logic        m_sd = 1'b0;
    logic [31:0] sb[$];

    lm70_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .temp_ready (temp_ready),
        .cs_n       (cs_n),
        .sck        (sck),
        .sio_in     (sio_in),
        .sio_out    (sio_out),
        .sio_oe     (sio_oe),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, expv);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] model_word();
        return m_sd ? 16'h8001 : {m_hold, 5'b11111};
    endfunction

    task automatic offer(input logic [10:0] v);
        temp_in    = v;
        temp_valid = 1'b1;
        check("rdy_idle", {31'd0, temp_ready}, 32'd1);
        clks(1);
        temp_valid = 1'b0;
        m_hold     = v;
        clks(1);
    endtask

    task automatic frame(input int nbits, input logic [7:0] cmd,
                         input int ncmd, input bit mid);
        logic [31:0] rd;
        logic [31:0] expv;
        logic [15:0] w;
        int d0;
        w = model_word();
        if (nbits <= 16) expv = 32'(w) >> (16 - nbits);
        else expv = 32'(w) << (nbits - 16);
        sb.push_back(expv);
        d0 = done_cyc;
        rd = 32'd0;
        cs_n = 1'b0;
        clks(6);
        check("oe_on", {31'd0, sio_oe}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            rd = {rd[30:0], sio_out};
            clks(6);
            sck = 1'b0;
            if (mid && i == 4) begin
                temp_in    = 11'h190;
                temp_valid = 1'b1;
                check("rdy_busy", {31'd0, temp_ready}, 32'd0);
                clks(1);
                temp_valid = 1'b0;
                clks(5);
            end else begin
                clks(6);
            end
        end
        for (int i = 0; i < ncmd; i++) begin
            sio_in = cmd[7-i];
            sck = 1'b1;
            if (i == 0) check("oe_cmd", {31'd0, sio_oe}, 32'd0);
            clks(6);
            sck = 1'b0;
            clks(6);
        end
        if (ncmd == 8) begin
            if (cmd == 8'hFF) m_sd = 1'b1;
            else if (cmd == 8'h00) m_sd = 1'b0;
        end
        cs_n = 1'b1;
        clks(8);
        check("read", rd, sb.pop_front());
        check("done", 32'(done_cyc - d0), (nbits >= 16) ? 32'd1 : 32'd0);
        check("oe_off", {31'd0, sio_oe}, 32'd0);
        check("busy_off", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int bad;
        clks(3);
        check("rst_oe", {31'd0, sio_oe}, 32'd0);
        check("rst_out", {31'd0, sio_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_rdy", {31'd0, temp_ready}, 32'd1);
        rst_n = 1'b1;
        clks(5);

        offer(11'h064);
        frame(16, 8'h00, 0, 1'b0);
        offer(11'h7FF);
        frame(8, 8'h00, 0, 1'b0);
        frame(16, 8'h00, 0, 1'b1);
        offer(11'h190);
        frame(16, 8'h00, 0, 1'b0);
        frame(20, 8'h00, 0, 1'b0);

        // reset during bit 7 with CS held low
        cs_n = 1'b0;
        clks(6);
        for (int i = 0; i < 7; i++) begin
            sck = 1'b1;
            clks(6);
            sck = 1'b0;
            clks(6);
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_oe", {31'd0, sio_oe}, 32'd0);
        clks(1);
        rst_n = 1'b1;
        m_hold = 11'h000;
        m_sd = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            sck = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (sio_oe) bad++;
            end
            sck = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (sio_oe) bad++;
            end
        end
        check("rst_quiet", 32'(bad), 32'd0);
        cs_n = 1'b1;
        clks(8);
        frame(16, 8'h00, 0, 1'b0);
        offer(11'h123);
        frame(16, 8'h00, 0, 1'b0);

`ifdef LM70_SHUTDOWN_EN
        frame(16, 8'hFF, 8, 1'b0);
        frame(16, 8'h00, 4, 1'b0);
        frame(16, 8'h00, 8, 1'b0);
        frame(16, 8'h00, 0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
